// File: rtl/fifo_pkg.sv
// Shared widths and flag bundle for the FIFO pointer/flag controller.
// Widths are derived from FIFO_DEPTH so that non-power-of-two depths size correctly.
package fifo_pkg;

  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
  } fifo_flags_t;

endpackage

// File: rtl/fifo_ctrl_if.sv
// Producer/consumer request bus and fifo_mem control signals of fifo_ctrl.
// Handshake: push/pop are requests; a request is taken exactly when write_enable/read_enable is high in the same cycle.
interface fifo_ctrl_if #(
  parameter int FIFO_DEPTH = 8
);
  localparam int AW = fifo_pkg::addr_w(FIFO_DEPTH);
  localparam int CW = fifo_pkg::cnt_w(FIFO_DEPTH);

  logic          push;
  logic          pop;
  logic          flush;
  logic          clear_errors;
  logic [AW-1:0] write_address;
  logic          write_enable;
  logic [AW-1:0] read_address;
  logic          read_enable;
  logic          rd_valid;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic          almost_empty;
  logic          overflow;
  logic          underflow;

  // Requester side: issues push/pop/flush/clear_errors and observes status.
  modport master (
    output push, pop, flush, clear_errors,
    input  write_address, write_enable, read_address, read_enable, rd_valid,
    input  count, full, empty, almost_full, almost_empty, overflow, underflow
  );

  // Controller side.
  modport slave (
    input  push, pop, flush, clear_errors,
    output write_address, write_enable, read_address, read_enable, rd_valid,
    output count, full, empty, almost_full, almost_empty, overflow, underflow
  );

endinterface

// File: rtl/fifo_ptr.sv
// Wrapping FIFO pointer: increments on inc, clears on flush, wraps at DEPTH-1 by compare.
module fifo_ptr #(
  parameter int DEPTH = 8,
  parameter int AW    = fifo_pkg::addr_w(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          inc,
  input  logic          flush,
  output logic [AW-1:0] ptr
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  logic [AW-1:0] ptr_q;
  logic [AW-1:0] ptr_d;

  // Explicit compare so depths that are not powers of two wrap correctly.
  always_comb begin
    ptr_d = ptr_q;
    if (flush) begin
      ptr_d = '0;
    end else if (inc) begin
      ptr_d = (ptr_q == LAST) ? '0 : ptr_q + AW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/fifo_ctrl.sv
// Pointer, occupancy, flag and sticky-error controller driving the synchronous fifo_mem.
// rd_valid is delayed one cycle to line up with fifo_mem's registered read data.
module fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int FIFO_DEPTH          = 8,
  parameter int ALMOST_FULL_THRESH  = FIFO_DEPTH - 1,
  parameter int ALMOST_EMPTY_THRESH = 1
) (
  input logic        clk,
  input logic        reset,
  fifo_ctrl_if.slave bus
);

  localparam int AW = addr_w(FIFO_DEPTH);
  localparam int CW = cnt_w(FIFO_DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] AF_TH   = CW'(ALMOST_FULL_THRESH);
  localparam logic [CW-1:0] AE_TH   = CW'(ALMOST_EMPTY_THRESH);

  logic [CW-1:0] count_q, count_d;
  logic          rd_valid_q, rd_valid_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;

  fifo_flags_t   flags;
  logic          pop_ok, push_ok;
  logic          pop_acc, push_acc;
  logic [AW-1:0] wr_ptr, rd_ptr;

  always_comb begin
    flags.full         = (count_q == DEPTH_C);
    flags.empty        = (count_q == '0);
    flags.almost_full  = (count_q >= AF_TH);
    flags.almost_empty = (count_q <= AE_TH);
  end

  // A push into a full FIFO is taken only when a pop frees a slot in the same cycle.
  // flush and reset mask the accepts so fifo_mem sees no access.
  always_comb begin
    pop_ok   = bus.pop & ~flags.empty;
    push_ok  = bus.push & (~flags.full | pop_ok);
    pop_acc  = pop_ok & ~bus.flush & reset;
    push_acc = push_ok & ~bus.flush & reset;
  end

  always_comb begin
    count_d    = count_q + CW'(push_acc) - CW'(pop_acc);
    rd_valid_d = pop_acc;
    if (bus.flush) begin
      count_d    = '0;
      rd_valid_d = 1'b0;
    end
  end

  // Sticky errors: a new error in the same cycle as clear_errors keeps the bit set.
  always_comb begin
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (bus.clear_errors) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
    if (bus.push & flags.full & ~pop_ok) overflow_d  = 1'b1;
    if (bus.pop & flags.empty)           underflow_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q     <= '0;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      rd_valid_q  <= rd_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  fifo_ptr #(.DEPTH(FIFO_DEPTH), .AW(AW)) u_wr_ptr (
    .clk   (clk),
    .reset (reset),
    .inc   (push_acc),
    .flush (bus.flush),
    .ptr   (wr_ptr)
  );

  fifo_ptr #(.DEPTH(FIFO_DEPTH), .AW(AW)) u_rd_ptr (
    .clk   (clk),
    .reset (reset),
    .inc   (pop_acc),
    .flush (bus.flush),
    .ptr   (rd_ptr)
  );

  assign bus.write_address = wr_ptr;
  assign bus.write_enable  = push_acc;
  assign bus.read_address  = rd_ptr;
  assign bus.read_enable   = pop_acc;
  assign bus.rd_valid      = rd_valid_q;
  assign bus.count         = count_q;
  assign bus.full          = flags.full;
  assign bus.empty         = flags.empty;
  assign bus.almost_full   = flags.almost_full;
  assign bus.almost_empty  = flags.almost_empty;
  assign bus.overflow      = overflow_q;
  assign bus.underflow     = underflow_q;

endmodule
